// File: rtl/acq_run_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acq_run_sequencer_pkg
// Desc     : Shared state encoding and default widths for the acquisition
//            run sequencer.
// Revision : 1.0  initial release
// ============================================================================
package acq_run_sequencer_pkg;

  localparam int unsigned c_cnt_w_dflt    = 24;
  localparam int unsigned c_idx_w_dflt    = 20;
  localparam int unsigned c_min_fs_dflt   = 3;
  localparam int unsigned c_trig_to_dflt  = 32'h00FF_FFFF;
  localparam int unsigned c_stop_gap_dflt = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/acq_run_sequencer_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : acq_run_sequencer_rise_detect
// Desc     : 1-bit registered rising-edge detector; history clears on reset.
// Revision : 1.0  initial release
// ============================================================================
module acq_run_sequencer_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic r_sig_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= sig;
    end
  end

  assign rise = sig & ~r_sig_d;

endmodule
`default_nettype wire

// File: rtl/acq_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acq_run_sequencer
// Desc     : Run-level controller for the sampling-clock generator and the
//            ADC/DAC sample path: start/stop, shadow config, sample strobes.
// Revision : 1.0  initial release
// ============================================================================
module acq_run_sequencer
  import acq_run_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W      = c_cnt_w_dflt,
  parameter int unsigned IDX_W      = c_idx_w_dflt,
  parameter int unsigned MIN_FS_CNT = c_min_fs_dflt,
  parameter int unsigned TRIG_TO    = c_trig_to_dflt,
  parameter int unsigned STOP_GAP   = c_stop_gap_dflt
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_start,
  input  logic             host_stop,
  input  logic [CNT_W-1:0] cfg_fs_cnt_max,
  input  logic [IDX_W-1:0] cfg_num_samples,
  input  logic             trigger,
  input  logic             fs_clk,
  input  logic             fifo_full,
  output logic             gen_start,
  output logic [CNT_W-1:0] gen_fs_cnt_max,
  output logic             sample_strobe,
  output logic [IDX_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic             err_overrun,
  output logic             err_trig_to
);

  localparam int unsigned c_gap_w = $clog2(STOP_GAP + 1);

  localparam logic [CNT_W-1:0]   c_min_fs    = CNT_W'(MIN_FS_CNT);
  localparam logic [CNT_W-1:0]   c_trig_last = CNT_W'(TRIG_TO - 1);
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
  localparam logic [IDX_W-1:0]   c_idx_one   = IDX_W'(1);
  localparam logic [c_gap_w-1:0] c_gap_one   = c_gap_w'(1);
  localparam logic [c_gap_w-1:0] c_gap_done  = c_gap_w'(STOP_GAP - 2);
  localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(STOP_GAP - 1);

  state_t             r_state;
  logic               r_gen_start;
  logic [CNT_W-1:0]   r_gen_fs_cnt_max;
  logic [IDX_W-1:0]   r_num_samples;
  logic               r_sample_strobe;
  logic [IDX_W-1:0]   r_sample_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_err_overrun;
  logic               r_err_trig_to;
  logic               r_adv;
  logic [CNT_W-1:0]   r_to_cnt;
  logic [c_gap_w-1:0] r_gap_cnt;

  logic               w_start_rise;
  logic               w_fs_rise;
  logic               w_stop_req;
  logic               w_last_sample;
  logic [CNT_W-1:0]   w_fs_floor;

  acq_run_sequencer_rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (host_start),
    .rise  (w_start_rise)
  );

  acq_run_sequencer_rise_detect u_fs_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (fs_clk),
    .rise  (w_fs_rise)
  );

  assign w_stop_req    = host_stop | ~host_start;
  assign w_fs_floor    = (cfg_fs_cnt_max < c_min_fs) ? c_min_fs : cfg_fs_cnt_max;
  assign w_last_sample = (r_num_samples != '0) &&
                         (r_sample_idx == (r_num_samples - c_idx_one));

  // r_adv marks the strobe cycle (issued or suppressed); the index moves on
  // only after that cycle so the strobe carries its own index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_gen_start      <= 1'b0;
      r_gen_fs_cnt_max <= '0;
      r_num_samples    <= '0;
      r_sample_strobe  <= 1'b0;
      r_sample_idx     <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_overrun    <= 1'b0;
      r_err_trig_to    <= 1'b0;
      r_adv            <= 1'b0;
      r_to_cnt         <= '0;
      r_gap_cnt        <= '0;
    end else begin
      r_sample_strobe <= 1'b0;
      r_done          <= 1'b0;
      r_adv           <= 1'b0;
      if (r_adv) begin
        r_sample_idx <= r_sample_idx + c_idx_one;
      end

      case (r_state)
        ST_IDLE: begin
          r_gen_start <= 1'b0;
          r_busy      <= 1'b0;
          if (w_start_rise) begin
            r_gen_fs_cnt_max <= w_fs_floor;
            r_num_samples    <= cfg_num_samples;
            r_err_overrun    <= 1'b0;
            r_err_trig_to    <= 1'b0;
            r_sample_idx     <= '0;
            r_to_cnt         <= '0;
            r_gen_start      <= 1'b1;
            r_busy           <= 1'b1;
            r_state          <= ST_ARM;
          end
        end

        ST_ARM: begin
          r_to_cnt <= r_to_cnt + c_cnt_one;
          if (w_stop_req) begin
            r_gen_start <= 1'b0;
            r_gap_cnt   <= '0;
            r_state     <= ST_STOP;
          end else if (trigger) begin
            r_state <= ST_RUN;
          end else if (r_to_cnt == c_trig_last) begin
            r_err_trig_to <= 1'b1;
            r_gen_start   <= 1'b0;
            r_gap_cnt     <= '0;
            r_state       <= ST_STOP;
          end
        end

        ST_RUN: begin
          if (w_stop_req) begin
            r_gen_start <= 1'b0;
            r_gap_cnt   <= '0;
            r_state     <= ST_STOP;
          end else begin
            if (w_fs_rise) begin
              r_sample_strobe <= ~fifo_full;
              r_adv           <= 1'b1;
              if (fifo_full) begin
                r_err_overrun <= 1'b1;
              end
            end
            if (r_adv && w_last_sample) begin
              r_gen_start <= 1'b0;
              r_gap_cnt   <= '0;
              r_state     <= ST_STOP;
            end
          end
        end

        ST_STOP: begin
          r_gap_cnt <= r_gap_cnt + c_gap_one;
          r_done    <= (r_gap_cnt == c_gap_done);
          if (r_gap_cnt == c_gap_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_gen_start <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign gen_start      = r_gen_start;
  assign gen_fs_cnt_max = r_gen_fs_cnt_max;
  assign sample_strobe  = r_sample_strobe;
  assign sample_idx     = r_sample_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_overrun    = r_err_overrun;
  assign err_trig_to    = r_err_trig_to;

endmodule
`default_nettype wire

// File: tb/tb_acq_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_run_sequencer
// Desc     : Directed self-checking bench for acq_run_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_acq_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_start;
  logic        host_stop;
  logic [23:0] cfg_fs_cnt_max;
  logic [19:0] cfg_num_samples;
  logic        trigger;
  logic        fs_clk;
  logic        fifo_full;
  logic        gen_start;
  logic [23:0] gen_fs_cnt_max;
  logic        sample_strobe;
  logic [19:0] sample_idx;
  logic        busy;
  logic        done;
  logic        err_overrun;
  logic        err_trig_to;

  int total = 0;
  int bad   = 0;
  bit gen_mode = 1'b0;
  int gcnt = 0;

  acq_run_sequencer #(
    .TRIG_TO (100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .host_start      (host_start),
    .host_stop       (host_stop),
    .cfg_fs_cnt_max  (cfg_fs_cnt_max),
    .cfg_num_samples (cfg_num_samples),
    .trigger         (trigger),
    .fs_clk          (fs_clk),
    .fifo_full       (fifo_full),
    .gen_start       (gen_start),
    .gen_fs_cnt_max  (gen_fs_cnt_max),
    .sample_strobe   (sample_strobe),
    .sample_idx      (sample_idx),
    .busy            (busy),
    .done            (done),
    .err_overrun     (err_overrun),
    .err_trig_to     (err_trig_to)
  );

  always #5 clk = ~clk;

  // One clock; optionally emulates the generator: fs_clk toggles every
  // gen_fs_cnt_max+1 clocks while gen_start is high.
  task automatic step();
    @(posedge clk);
    #1;
    if (gen_mode) begin
      if (!gen_start) begin
        gcnt   = 0;
        fs_clk = 1'b0;
      end else if (gcnt == int'(gen_fs_cnt_max)) begin
        gcnt   = 0;
        fs_clk = ~fs_clk;
      end else begin
        gcnt++;
      end
    end
  endtask

  task automatic start_run(input logic [23:0] fs, input logic [19:0] num);
    cfg_fs_cnt_max  = fs;
    cfg_num_samples = num;
    host_start = 1'b0;
    step();
    host_start = 1'b1;
    step();
  endtask

  // fs_clk low for 4 clocks, then rises; returns in the cycle after the rise.
  task automatic fs_pulse(input bit full, input bit stop);
    fs_clk = 1'b0;
    repeat (4) step();
    fs_clk    = 1'b1;
    fifo_full = full;
    host_stop = stop;
    step();
    fifo_full = 1'b0;
    host_stop = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      step();
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; host_start = 1'b0; host_stop = 1'b0; trigger = 1'b0;
    fs_clk = 1'b0; fifo_full = 1'b0; cfg_fs_cnt_max = 24'd7; cfg_num_samples = 20'd5;
    step(); step();
    total++;
    if ({gen_start, busy, done, sample_strobe, err_overrun, err_trig_to} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000",
               {gen_start, busy, done, sample_strobe, err_overrun, err_trig_to});
    end
    total++;
    if (gen_fs_cnt_max !== 24'd0 || sample_idx !== 20'd0) begin
      bad++;
      $display("FAIL reset_values fs=%0d idx=%0d exp 0/0", gen_fs_cnt_max, sample_idx);
    end
    reset = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_run_of_4();
    int  ns, done_cyc;
    int  st_cyc[4];
    int  st_idx[4];
    bit  gs[200];
    bit  bz[200];
    gen_mode = 1'b1; gcnt = 0; fs_clk = 1'b0;
    start_run(24'd3, 20'd4);
    total++;
    if (busy !== 1'b1 || gen_start !== 1'b1 || gen_fs_cnt_max !== 24'd3) begin
      bad++;
      $display("FAIL run4_arm busy=%b gen_start=%b fs=%0d exp 1/1/3", busy, gen_start, gen_fs_cnt_max);
    end
    repeat (10) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    ns = 0; done_cyc = -1;
    for (int c = 0; c < 200; c++) begin
      step();
      gs[c] = gen_start;
      bz[c] = busy;
      if (sample_strobe) begin
        if (ns < 4) begin
          st_cyc[ns] = c;
          st_idx[ns] = int'(sample_idx);
        end
        ns++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
    end
    total++;
    if (ns != 4) begin
      bad++; $display("FAIL run4_count got=%0d exp=4", ns);
    end
    if (ns >= 4) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (st_idx[i] != i) begin
          bad++; $display("FAIL run4_idx%0d got=%0d exp=%0d", i, st_idx[i], i);
        end
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (st_cyc[i+1] - st_cyc[i] != 8) begin
          bad++; $display("FAIL run4_spacing%0d got=%0d exp=8", i, st_cyc[i+1] - st_cyc[i]);
        end
      end
      total++;
      if (gs[st_cyc[3]] !== 1'b1 || gs[st_cyc[3] + 1] !== 1'b0) begin
        bad++;
        $display("FAIL run4_gen_drop at_strobe=%b after=%b exp 1/0", gs[st_cyc[3]], gs[st_cyc[3] + 1]);
      end
    end
    total++;
    if (done_cyc < 0 || ns < 4 || done_cyc - st_cyc[3] != 4) begin
      bad++; $display("FAIL run4_done_lat got=%0d exp=4", done_cyc - st_cyc[3]);
    end
    if (done_cyc >= 0 && done_cyc + 1 < 200) begin
      total++;
      if (bz[done_cyc] !== 1'b1 || bz[done_cyc + 1] !== 1'b0) begin
        bad++;
        $display("FAIL run4_busy at_done=%b after=%b exp 1/0", bz[done_cyc], bz[done_cyc + 1]);
      end
    end
    host_start = 1'b0; gen_mode = 1'b0; fs_clk = 1'b0;
    step();
  endtask

  task automatic test_floor();
    int n;
    bit seen;
    start_run(24'd0, 20'd0);
    total++;
    if (gen_fs_cnt_max !== 24'd3) begin
      bad++; $display("FAIL floor_zero got=%0d exp=3", gen_fs_cnt_max);
    end
    cfg_fs_cnt_max = 24'd50;
    step();
    total++;
    if (gen_fs_cnt_max !== 24'd3) begin
      bad++; $display("FAIL shadow_hold got=%0d exp=3", gen_fs_cnt_max);
    end
    host_start = 1'b0;
    wait_done(10, n, seen);
    total++;
    if (!seen || n != 4) begin
      bad++; $display("FAIL floor_stop_done seen=%b n=%0d exp 1/4", seen, n);
    end
    start_run(24'd10, 20'd0);
    total++;
    if (gen_fs_cnt_max !== 24'd10) begin
      bad++; $display("FAIL floor_pass got=%0d exp=10", gen_fs_cnt_max);
    end
    host_start = 1'b0;
    wait_done(10, n, seen);
    step();
  endtask

  task automatic test_overrun();
    int n;
    bit seen;
    start_run(24'd3, 20'd4);
    trigger = 1'b1; step(); trigger = 1'b0;
    fs_pulse(1'b0, 1'b0);
    total++;
    if (sample_strobe !== 1'b1 || sample_idx !== 20'd0) begin
      bad++; $display("FAIL ovr_s0 strobe=%b idx=%0d exp 1/0", sample_strobe, sample_idx);
    end
    fs_pulse(1'b1, 1'b0);
    total++;
    if (sample_strobe !== 1'b0 || err_overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_drop strobe=%b err=%b exp 0/1", sample_strobe, err_overrun);
    end
    fs_pulse(1'b0, 1'b0);
    total++;
    if (sample_strobe !== 1'b1 || sample_idx !== 20'd2) begin
      bad++; $display("FAIL ovr_s2 strobe=%b idx=%0d exp 1/2", sample_strobe, sample_idx);
    end
    fs_pulse(1'b0, 1'b0);
    total++;
    if (sample_strobe !== 1'b1 || sample_idx !== 20'd3) begin
      bad++; $display("FAIL ovr_s3 strobe=%b idx=%0d exp 1/3", sample_strobe, sample_idx);
    end
    fs_clk = 1'b0;
    step();
    total++;
    if (gen_start !== 1'b0) begin
      bad++; $display("FAIL ovr_gen_drop got=%b exp=0", gen_start);
    end
    wait_done(10, n, seen);
    total++;
    if (!seen || n != 3 || err_overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_done seen=%b n=%0d err=%b exp 1/3/1", seen, n, err_overrun);
    end
    step();
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    start_run(24'd3, 20'd8);
    total++;
    if (err_overrun !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_start err=%b busy=%b exp 0/1", err_overrun, busy);
    end
    trigger = 1'b1; step(); trigger = 1'b0;
    fs_pulse(1'b0, 1'b0);
    fs_pulse(1'b0, 1'b0);
    total++;
    if (sample_strobe !== 1'b1 || sample_idx !== 20'd1) begin
      bad++; $display("FAIL abort_s1 strobe=%b idx=%0d exp 1/1", sample_strobe, sample_idx);
    end
    fs_pulse(1'b0, 1'b1);
    total++;
    if (sample_strobe !== 1'b0 || gen_start !== 1'b0) begin
      bad++; $display("FAIL abort_stop strobe=%b gen_start=%b exp 0/0", sample_strobe, gen_start);
    end
    host_start = 1'b0; fs_clk = 1'b0;
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL abort_early_done got=%b exp=0", done);
    end
    host_start = 1'b1;
    step();
    wait_done(10, n, seen);
    total++;
    if (!seen || n != 1) begin
      bad++; $display("FAIL abort_done seen=%b n=%0d exp 1/1", seen, n);
    end
    step(); step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL stop_rise_ignored busy=%b exp=0", busy);
    end
  endtask

  task automatic test_trig_timeout();
    int n;
    bit seen;
    start_run(24'd3, 20'd4);
    repeat (99) step();
    total++;
    if (err_trig_to !== 1'b0 || gen_start !== 1'b1) begin
      bad++; $display("FAIL to_early err=%b gen_start=%b exp 0/1", err_trig_to, gen_start);
    end
    step();
    total++;
    if (err_trig_to !== 1'b1 || gen_start !== 1'b0) begin
      bad++; $display("FAIL to_fire err=%b gen_start=%b exp 1/0", err_trig_to, gen_start);
    end
    wait_done(10, n, seen);
    total++;
    if (!seen || n != 3 || err_trig_to !== 1'b1) begin
      bad++; $display("FAIL to_done seen=%b n=%0d err=%b exp 1/3/1", seen, n, err_trig_to);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    int n;
    bit seen;
    start_run(24'd3, 20'd0);
    trigger = 1'b1; step(); trigger = 1'b0;
    fs_pulse(1'b1, 1'b0);
    fs_pulse(1'b0, 1'b0);
    fs_pulse(1'b0, 1'b0);
    total++;
    if (sample_idx !== 20'd2 || err_overrun !== 1'b1) begin
      bad++; $display("FAIL mid_pre idx=%0d err=%b exp 2/1", sample_idx, err_overrun);
    end
    reset = 1'b1;
    step();
    total++;
    if ({gen_start, busy, done, sample_strobe, err_overrun, err_trig_to} !== 6'b0 ||
        sample_idx !== 20'd0 || gen_fs_cnt_max !== 24'd0) begin
      bad++;
      $display("FAIL mid_reset flags=%b idx=%0d fs=%0d exp 0",
               {gen_start, busy, done, sample_strobe, err_overrun, err_trig_to},
               sample_idx, gen_fs_cnt_max);
    end
    reset = 1'b0; fs_clk = 1'b0;
    start_run(24'd3, 20'd0);
    total++;
    if (busy !== 1'b1 || err_overrun !== 1'b0 || sample_idx !== 20'd0) begin
      bad++; $display("FAIL mid_restart busy=%b err=%b idx=%0d exp 1/0/0", busy, err_overrun, sample_idx);
    end
    trigger = 1'b1; step(); trigger = 1'b0;
    fs_pulse(1'b0, 1'b0);
    total++;
    if (sample_strobe !== 1'b1 || sample_idx !== 20'd0) begin
      bad++; $display("FAIL mid_first strobe=%b idx=%0d exp 1/0", sample_strobe, sample_idx);
    end
    host_stop = 1'b1; step(); host_stop = 1'b0;
    wait_done(10, n, seen);
    host_start = 1'b0; fs_clk = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_run_of_4();
    test_floor();
    test_overrun();
    test_abort();
    test_trig_timeout();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
